// File: rtl/msf_frame_encoder.sv
// MSF transmit encoder: serialises a staged BCD time/date into the 60 s, 100 ms-slot keying pattern.
// Optional: define MSF_BST_EN to add bst_i (B58) and bst_warn_i (B53).
module msf_frame_encoder #(
    parameter int unsigned CLKS_PER_SLOT = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       load_i,
    input  logic [3:0] year_h_i,
    input  logic [3:0] year_l_i,
    input  logic       month_h_i,
    input  logic [3:0] month_l_i,
    input  logic [1:0] day_h_i,
    input  logic [3:0] day_l_i,
    input  logic [2:0] dow_i,
    input  logic [1:0] hour_h_i,
    input  logic [3:0] hour_l_i,
    input  logic [2:0] minute_h_i,
    input  logic [3:0] minute_l_i,
`ifdef MSF_BST_EN
    input  logic       bst_i,
    input  logic       bst_warn_i,
`endif
    output logic       msf_o,
    output logic       second_tick_o,
    output logic       frame_start_o,
    output logic       pending_o
);

    localparam int unsigned CW = (CLKS_PER_SLOT > 1) ? $clog2(CLKS_PER_SLOT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_SLOT - 1);
`ifdef MSF_BST_EN
    localparam int unsigned FW = 37;
`else
    localparam int unsigned FW = 35;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    slot_q, slot_d;
    logic [5:0]    sec_q, sec_d;
    logic [FW-1:0] staging_q, staging_d;
    logic [FW-1:0] shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          msf_q, msf_d;
    logic          tick_q, tick_d;
    logic          fstart_q, fstart_d;
    logic [FW-1:0] fields_in;
    logic          bst_s, warn_s;

    // Field vector MSB is A17, bit 0 is A51; BST flags sit above it.
`ifdef MSF_BST_EN
    assign fields_in = {bst_warn_i, bst_i, year_h_i, year_l_i, month_h_i, month_l_i, day_h_i,
                        day_l_i, dow_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i};
    assign bst_s  = shadow_q[35];
    assign warn_s = shadow_q[36];
`else
    assign fields_in = {year_h_i, year_l_i, month_h_i, month_l_i, day_h_i,
                        day_l_i, dow_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i};
    assign bst_s  = 1'b0;
    assign warn_s = 1'b0;
`endif

    function automatic logic a_bit(input logic [5:0] s, input logic [34:0] f);
        logic [5:0] idx;
        idx = 6'd51 - s;
        if (s >= 6'd17 && s <= 6'd51) return f[idx];
        return (s >= 6'd53 && s <= 6'd58);
    endfunction

    function automatic logic b_bit(input logic [5:0] s, input logic [34:0] f,
                                   input logic warn, input logic bst);
        case (s)
            6'd53:   return warn;
            6'd54:   return ~^f[34:27];
            6'd55:   return ~^f[26:16];
            6'd56:   return ~^f[15:13];
            6'd57:   return ~^f[12:0];
            6'd58:   return bst;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic slot_level(input logic [5:0] s, input logic [3:0] sl,
                                        input logic [34:0] f, input logic warn, input logic bst);
        if (s == 6'd0) return (sl < 4'd5);
        case (sl)
            4'd0:    return 1'b1;
            4'd1:    return a_bit(s, f);
            4'd2:    return b_bit(s, f, warn, bst);
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        slot_d    = slot_q;
        sec_d     = sec_q;
        staging_d = staging_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        msf_d     = msf_q;
        tick_d    = 1'b0;
        fstart_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                slot_d = '0;
                sec_d  = '0;
                msf_d  = 1'b0;
                if (enable_i) begin
                    state_d  = RUN;
                    tick_d   = 1'b1;
                    fstart_d = 1'b1;
                    msf_d    = 1'b1;
                    if (pending_q) shadow_d = staging_q;
                    pending_d = 1'b0;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    slot_d  = '0;
                    sec_d   = '0;
                    msf_d   = 1'b0;
                end else begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d  = '0;
                        tick_d = (slot_q == 4'd9);
                        if (slot_q == 4'd9) begin
                            slot_d = '0;
                            sec_d  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                        end else begin
                            slot_d = slot_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_q == CNT_MAX && slot_q == 4'd9 && sec_q == 6'd59) begin
                        fstart_d = 1'b1;
                        if (pending_q) shadow_d = staging_q;
                        pending_d = 1'b0;
                    end
                    msf_d = slot_level(sec_d, slot_d, shadow_q[34:0], warn_s, bst_s);
                end
            end
            default: state_d = IDLE;
        endcase

        // A load during the boundary cycle goes straight into the frame being sent.
        if (load_i) begin
            staging_d = fields_in;
            if (fstart_q) begin
                shadow_d  = fields_in;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            slot_q    <= '0;
            sec_q     <= '0;
            staging_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            msf_q     <= 1'b0;
            tick_q    <= 1'b0;
            fstart_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            sec_q     <= sec_d;
            staging_q <= staging_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            msf_q     <= msf_d;
            tick_q    <= tick_d;
            fstart_q  <= fstart_d;
        end
    end

    assign msf_o         = msf_q;
    assign second_tick_o = tick_q;
    assign frame_start_o = fstart_q;
    assign pending_o     = pending_q;

endmodule

// File: tb/tb_msf_frame_encoder.sv
// Bench for msf_frame_encoder: time-indexed frame model checked every cycle, plus literal bit checks.
module tb_msf_frame_encoder;

    localparam int unsigned CPS = 4;
    localparam int FRAME = 2400;
`ifdef MSF_BST_EN
    localparam int BST_EXP = 1;
`else
    localparam int BST_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst, en, load;
    logic [3:0] year_h, year_l, month_l, day_l, hour_l, minute_l;
    logic       month_h;
    logic [1:0] day_h, hour_h;
    logic [2:0] dow, minute_h;
`ifdef MSF_BST_EN
    logic bst, bst_warn;
`endif
    logic msf_o, second_tick_o, frame_start_o, pending_o;

    initial forever #5 clk = ~clk;

    msf_frame_encoder #(.CLKS_PER_SLOT(CPS)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .load_i(load),
        .year_h_i(year_h), .year_l_i(year_l), .month_h_i(month_h), .month_l_i(month_l),
        .day_h_i(day_h), .day_l_i(day_l), .dow_i(dow), .hour_h_i(hour_h), .hour_l_i(hour_l),
        .minute_h_i(minute_h), .minute_l_i(minute_l),
`ifdef MSF_BST_EN
        .bst_i(bst), .bst_warn_i(bst_warn),
`endif
        .msf_o(msf_o), .second_tick_o(second_tick_o),
        .frame_start_o(frame_start_o), .pending_o(pending_o)
    );

    typedef struct {
        int year; int month; int day; int dow; int hour; int minute; int bst; int warn;
    } tdate_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // BCD weights: upper bits are tens (..,40,20,10), lower four are units (8,4,2,1).
    function automatic logic [59:0] put_bcd(input logic [59:0] a_in, input int first,
                                            input int val, input int nbits);
        logic [59:0] a;
        int v, w;
        a = a_in;
        v = val;
        for (int i = 0; i < nbits; i++) begin
            if (i < nbits - 4) w = 10 << (nbits - 5 - i);
            else w = 8 >> (i - (nbits - 4));
            if (v >= w) begin
                a[first + i] = 1'b1;
                v -= w;
            end
        end
        return a;
    endfunction

    function automatic logic [59:0] model_a(input tdate_t t);
        logic [59:0] a;
        a = '0;
        a = put_bcd(a, 17, t.year, 8);
        a = put_bcd(a, 25, t.month, 5);
        a = put_bcd(a, 30, t.day, 6);
        a = put_bcd(a, 36, t.dow, 3);
        a = put_bcd(a, 39, t.hour, 6);
        a = put_bcd(a, 45, t.minute, 7);
        for (int s = 53; s <= 58; s++) a[s] = 1'b1;
        return a;
    endfunction

    function automatic logic odd_fill(input logic [59:0] a, input int lo, input int hi);
        int n;
        n = 0;
        for (int s = lo; s <= hi; s++) n += int'(a[s]);
        return (n % 2 == 0);
    endfunction

    function automatic logic [59:0] model_b(input tdate_t t);
        logic [59:0] a, b;
        a = model_a(t);
        b = '0;
        b[53] = (t.warn != 0);
        b[54] = odd_fill(a, 17, 24);
        b[55] = odd_fill(a, 25, 35);
        b[56] = odd_fill(a, 36, 38);
        b[57] = odd_fill(a, 39, 51);
        b[58] = (t.bst != 0);
        return b;
    endfunction

    function automatic logic model_msf(input int k, input tdate_t t);
        int s, sl;
        logic [59:0] a, b;
        s  = k / 40;
        sl = (k % 40) / 4;
        a  = model_a(t);
        b  = model_b(t);
        if (s == 0) return (sl < 5);
        if (sl == 0) return 1'b1;
        if (sl == 1) return a[s];
        if (sl == 2) return b[s];
        return 1'b0;
    endfunction

    function automatic tdate_t read_inputs();
        tdate_t t;
        t.year   = int'(year_h) * 10 + int'(year_l);
        t.month  = int'(month_h) * 10 + int'(month_l);
        t.day    = int'(day_h) * 10 + int'(day_l);
        t.dow    = int'(dow);
        t.hour   = int'(hour_h) * 10 + int'(hour_l);
        t.minute = int'(minute_h) * 10 + int'(minute_l);
`ifdef MSF_BST_EN
        t.bst    = int'(bst);
        t.warn   = int'(bst_warn);
`else
        t.bst    = 0;
        t.warn   = 0;
`endif
        return t;
    endfunction

    task automatic set_date(input tdate_t t);
        year_h   = 4'(t.year / 10);   year_l   = 4'(t.year % 10);
        month_h  = 1'(t.month / 10);  month_l  = 4'(t.month % 10);
        day_h    = 2'(t.day / 10);    day_l    = 4'(t.day % 10);
        dow      = 3'(t.dow);
        hour_h   = 2'(t.hour / 10);   hour_l   = 4'(t.hour % 10);
        minute_h = 3'(t.minute / 10); minute_l = 4'(t.minute % 10);
`ifdef MSF_BST_EN
        bst      = 1'(t.bst);
        bst_warn = 1'(t.warn);
`endif
    endtask

    // Model: k is the cycle index inside the current frame (0..2399).
    logic   m_valid = 1'b0;
    logic   m_run, m_msf, m_tick, m_fs, m_pend;
    int     m_k;
    tdate_t m_staging, m_shadow;
    int     cyc = 0;

    always @(posedge clk) begin : model_p
        tdate_t din;
        logic fs_prev, entered;
        cyc++;
        din = read_inputs();
        if (rst) begin
            m_valid   = 1'b1;
            m_run     = 1'b0;
            m_k       = 0;
            m_staging = '{default: 0};
            m_shadow  = '{default: 0};
            m_pend    = 1'b0;
            m_msf     = 1'b0;
            m_tick    = 1'b0;
            m_fs      = 1'b0;
        end else begin
            fs_prev = m_fs;
            entered = 1'b0;
            if (!m_run) begin
                if (en) begin
                    m_run = 1'b1;
                    m_k = 0;
                    entered = 1'b1;
                end
            end else if (!en) begin
                m_run = 1'b0;
                m_k = 0;
            end else begin
                m_k = (m_k + 1) % FRAME;
                entered = (m_k == 0);
            end
            if (entered) begin
                if (m_pend) m_shadow = m_staging;
                m_pend = 1'b0;
            end
            if (load) begin
                m_staging = din;
                if (fs_prev) begin
                    m_shadow = din;
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end
            m_fs   = m_run && entered;
            m_tick = m_run && (m_k % 40 == 0);
            m_msf  = m_run ? model_msf(m_k, m_shadow) : 1'b0;
        end
    end

    logic [59:0] cap_a, cap_b;
    int last_fs = 0, prev_fs = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("msf_o", int'(msf_o), int'(m_msf));
            chk("second_tick_o", int'(second_tick_o), int'(m_tick));
            chk("frame_start_o", int'(frame_start_o), int'(m_fs));
            chk("pending_o", int'(pending_o), int'(m_pend));
            if (m_run && ((m_k % 40) / 4) == 1) cap_a[m_k / 40] = msf_o;
            if (m_run && ((m_k % 40) / 4) == 2) cap_b[m_k / 40] = msf_o;
            if (frame_start_o) begin
                prev_fs = last_fs;
                last_fs = cyc;
            end
        end
    end

    function automatic int bits_of(input logic [59:0] c, input int lo, input int hi);
        int v;
        v = 0;
        for (int s = lo; s <= hi; s++) v = (v << 1) | int'(c[s]);
        return v;
    endfunction

    task automatic wait_k(input int target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (m_run && m_k == target) found = 1'b1;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_k: frame position %0d not reached, expected within 3000 cycles", target);
        end
    endtask

    initial begin : stim
        tdate_t d;
        logic seen;
        rst = 1'b1; en = 1'b1; load = 1'b0;
        d = '{year: 0, month: 0, day: 0, dow: 0, hour: 0, minute: 0, bst: 0, warn: 0};
        set_date(d);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            load = ~load;
        end
        @(negedge clk);
        chk("reset_msf", int'(msf_o), 0);
        chk("reset_pending", int'(pending_o), 0);
        chk("reset_frame_start", int'(frame_start_o), 0);
        chk("reset_tick", int'(second_tick_o), 0);
        load = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        chk("frame_start_after_release", int'(frame_start_o), 1);
        repeat (50) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);

        d = '{year: 23, month: 3, day: 15, dow: 3, hour: 14, minute: 37, bst: BST_EXP, warn: 0};
        set_date(d);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("pending_after_load", int'(pending_o), 1);
        en = 1'b1;
        @(negedge clk);
        chk("frame1_start", int'(frame_start_o), 1);
        chk("pending_cleared_frame1", int'(pending_o), 0);

        wait_k(30 * 40);
        d.minute = 38;
        set_date(d);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("pending_staged_sec30", int'(pending_o), 1);

        wait_k(0);
        #1;
        chk("frame_period", last_fs - prev_fs, FRAME);
        chk("pending_cleared_frame2", int'(pending_o), 0);
        chk("a17_24_year", bits_of(cap_a, 17, 24), 8'b00100011);
        chk("a25_29_month", bits_of(cap_a, 25, 29), 5'b00011);
        chk("a30_35_day", bits_of(cap_a, 30, 35), 6'b010101);
        chk("a45_51_min37", bits_of(cap_a, 45, 51), 7'b0110111);
        chk("b54_57", bits_of(cap_b, 54, 57), 4'b0010);
        chk("a53_58", bits_of(cap_a, 53, 58), 6'b111111);
        chk("b53", int'(cap_b[53]), 0);
        chk("b58", int'(cap_b[58]), BST_EXP);

        wait_k(FRAME - 1);
        chk("a45_51_min38", bits_of(cap_a, 45, 51), 7'b0111000);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            seen = frame_start_o;
        end
        chk("frame3_start_seen", int'(seen), 1);
        d.minute = 44;
        set_date(d);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("pending_bypass", int'(pending_o), 0);
        wait_k(59 * 40);
        chk("a45_51_min44_bypass", bits_of(cap_a, 45, 51), 7'b1000100);
        chk("b57_min44", int'(cap_b[57]), 1);

        wait_k(17 * 40 + 4);
        en = 1'b0;
        @(negedge clk);
        chk("disable_msf", int'(msf_o), 0);
        chk("disable_tick", int'(second_tick_o), 0);
        chk("disable_frame_start", int'(frame_start_o), 0);
        repeat (8) @(negedge clk);
        chk("idle_msf", int'(msf_o), 0);
        en = 1'b1;
        @(negedge clk);
        chk("reenable_frame_start", int'(frame_start_o), 1);
        chk("reenable_tick", int'(second_tick_o), 1);
        chk("reenable_msf", int'(msf_o), 1);
        repeat (100) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
